// File: rtl/image_capture_pkg.sv
// Shared types and constants for the image capture writer: FSM encoding,
// pixels-per-word packing factor and Avalon byte-enable patterns.
package image_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_LINE,
    S_LINE_END
  } state_t;

  localparam int PIX_PER_WORD = 4;

  localparam logic [3:0] BE_1 = 4'b0001;
  localparam logic [3:0] BE_2 = 4'b0011;
  localparam logic [3:0] BE_3 = 4'b0111;
  localparam logic [3:0] BE_4 = 4'b1111;

  // Byte enables for a word whose highest filled lane is 'lane'.
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    case (lane)
      2'd0:    return BE_1;
      2'd1:    return BE_2;
      2'd2:    return BE_3;
      default: return BE_4;
    endcase
  endfunction

endpackage

// File: rtl/pixel_packer_32.sv
// Packs 8-bit pixels little-endian into 32-bit words; flushes a partial word
// on the line's last pixel and holds the issued word while the bus stalls.
module pixel_packer_32
  import image_capture_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_lane,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        stall,
  output logic        issue,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [3:0]  word_be
);

  logic [31:0] acc;
  logic [31:0] merged;

  // Lane 0 starts from zero, so unused bytes of a partial word stay 0 and
  // bytes left over from an aborted line are discarded.
  always_comb begin
    merged = (in_lane == 2'd0) ? 32'd0 : acc;
    merged = merged | ({24'd0, in_data} << {in_lane, 3'b000});
    issue  = in_valid && ((in_lane == 2'(PIX_PER_WORD - 1)) || in_last);
  end

  // NOTE: all state here uses non-blocking assignments; merged is combinational
  // so acc and the word register both see the same freshly merged value.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_be    <= '0;
    end else begin
      if (in_valid) acc <= merged;
      if (!(word_valid && stall)) begin
        word_valid <= issue;
        if (issue) begin
          word_data <= merged;
          word_be   <= lane_be(in_lane);
        end
      end
    end
  end

endmodule

// File: rtl/image_capture_writer.sv
// Camera capture writer: packs grey pixels into words and writes each line to
// alternating buffers over Avalon-MM. Optional FRAME_CNT_EN adds frame_count.
module image_capture_writer
  import image_capture_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_capture,
  input  logic [ADDR_W-1:0] buff0,
  input  logic [ADDR_W-1:0] buff1,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  height,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  output logic              buff0full,
  output logic              buff1full,
  output logic              busy,
  output logic              frame_done
`ifdef FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0]  frame_count
`endif
);

  state_t state, state_n;
  logic [CNT_W-1:0]  width_l, height_l, pix_cnt, fill_line, word_idx, wr_line;
  logic [ADDR_W-1:0] buff0_l, buff1_l;
  logic fill_sel, fill_done, wr_sel, pend, m_last;
  logic pix_acc, restart, pkt_valid, is_last, land, last_line_wr, issue;
  logic [CNT_W-1:0] eff_pix, eff_line, eff_widx;
  logic eff_sel;

  always_comb begin
    pix_ready = 1'b0;
    case (state)
      S_IDLE, S_WAIT_SOF: pix_ready = 1'b1;
      S_LINE:             pix_ready = !(m_write && m_waitrequest);
      default:            pix_ready = 1'b0;
    endcase
  end

  // The fill side (pixels being packed) may run one pixel ahead of the write
  // side (lines landed), so each keeps its own line/buffer tracking.
  assign pix_acc   = pix_valid && pix_ready;
  assign restart   = pix_acc && pix_sof && (state == S_WAIT_SOF || state == S_LINE);
  assign pkt_valid = restart || (pix_acc && state == S_LINE && !fill_done);
  assign eff_pix   = restart ? '0 : pix_cnt;
  assign eff_line  = restart ? '0 : fill_line;
  assign eff_widx  = restart ? '0 : word_idx;
  assign eff_sel   = restart ? 1'b0 : fill_sel;
  assign is_last   = (eff_pix == width_l - CNT_W'(1));
  assign land      = m_write && !m_waitrequest && m_last;
  assign last_line_wr = (wr_line == height_l - CNT_W'(1));
  assign busy      = (state != S_IDLE);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_n    = state;
    buff0full  = 1'b0;
    buff1full  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:
        if (start_capture && width != '0 && height != '0) state_n = S_WAIT_SOF;
      S_WAIT_SOF:
        if (restart)             state_n = S_LINE;
        else if (!start_capture) state_n = S_IDLE;
      S_LINE:
        if (!restart && (land || pend)) state_n = S_LINE_END;
      S_LINE_END: begin
        buff0full = !wr_sel;
        buff1full = wr_sel;
        if (last_line_wr) begin
          frame_done = 1'b1;
          state_n    = start_capture ? S_WAIT_SOF : S_IDLE;
        end else begin
          state_n = S_LINE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_l   <= '0;
      height_l  <= '0;
      buff0_l   <= '0;
      buff1_l   <= '0;
      pix_cnt   <= '0;
      fill_line <= '0;
      word_idx  <= '0;
      fill_sel  <= 1'b0;
      fill_done <= 1'b0;
      wr_line   <= '0;
      wr_sel    <= 1'b0;
      pend      <= 1'b0;
      m_address <= '0;
      m_last    <= 1'b0;
    end else begin
      if (state == S_IDLE && state_n == S_WAIT_SOF) begin
        width_l  <= width;
        height_l <= height;
        buff0_l  <= buff0;
        buff1_l  <= buff1;
      end

      if (restart) begin
        wr_line <= '0;
        wr_sel  <= 1'b0;
        pend    <= 1'b0;
      end else if (state == S_LINE_END) begin
        pend <= land;
        if (!last_line_wr) begin
          wr_line <= wr_line + CNT_W'(1);
          wr_sel  <= !wr_sel;
        end
      end else if (state == S_LINE && (land || pend)) begin
        pend <= 1'b0;
      end

      if (pkt_valid) begin
        if (is_last) begin
          pix_cnt   <= '0;
          word_idx  <= '0;
          fill_sel  <= !eff_sel;
          fill_line <= eff_line + CNT_W'(1);
          fill_done <= (eff_line == height_l - CNT_W'(1));
        end else begin
          pix_cnt   <= eff_pix + CNT_W'(1);
          word_idx  <= issue ? eff_widx + CNT_W'(1) : eff_widx;
          fill_sel  <= eff_sel;
          fill_line <= eff_line;
          fill_done <= 1'b0;
        end
      end

      if (issue && !(m_write && m_waitrequest)) begin
        m_address <= (eff_sel ? buff1_l : buff0_l) + ADDR_W'({eff_widx, 2'b00});
        m_last    <= is_last;
      end
    end
  end

  pixel_packer_32 u_packer (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (pkt_valid),
    .in_lane    (eff_pix[1:0]),
    .in_data    (pix_data),
    .in_last    (is_last),
    .stall      (m_waitrequest),
    .issue      (issue),
    .word_valid (m_write),
    .word_data  (m_writedata),
    .word_be    (m_byteenable)
  );

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)           frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_image_capture_writer.sv
// Directed bench for image_capture_writer: expected writes and pulse counts
// per scenario are tabulated up front and compared after each sequence.
module tb_image_capture_writer;

  logic        clk = 1'b0;
  logic        reset, start_capture;
  logic [31:0] buff0, buff1;
  logic [15:0] width, height;
  logic        pix_valid, pix_sof, pix_ready;
  logic [7:0]  pix_data;
  logic [31:0] m_address, m_writedata;
  logic        m_write, m_waitrequest;
  logic [3:0]  m_byteenable;
  logic        buff0full, buff1full, busy, frame_done;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  always #5 clk = ~clk;

  image_capture_writer dut (
    .clk(clk), .reset(reset), .start_capture(start_capture),
    .buff0(buff0), .buff1(buff1), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .buff0full(buff0full), .buff1full(buff1full), .busy(busy), .frame_done(frame_done)
`ifdef FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  typedef struct { int test; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } wr_vec_t;
  typedef struct { int n_wr; int full0; int full1; int done; int full0_at; } sum_vec_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } obs_t;

  wr_vec_t  wr_tbl[$];
  sum_vec_t sum_tbl[1:6];
  obs_t     obs[$];

  int checks = 0, failures = 0;
  int n_full0, n_full1, n_done, full0_at, n_stall;
  logic        prev_stall;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_wr(input int t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_vec_t v;
    v.test = t; v.addr = a; v.data = d; v.be = be;
    wr_tbl.push_back(v);
  endtask

  // Bus monitor: logs accepted writes and pulses, checks hold-under-stall.
  initial begin
    obs_t o;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && prev_stall) begin
        check("stall_write", {31'd0, m_write}, 32'd1);
        check("stall_addr", m_address, p_addr);
        check("stall_data", m_writedata, p_data);
        check("stall_be", {28'd0, m_byteenable}, {28'd0, p_be});
      end
      if (m_write && !m_waitrequest) begin
        o.addr = m_address; o.data = m_writedata; o.be = m_byteenable;
        obs.push_back(o);
      end
      if (buff0full) begin
        if (n_full0 == 0) full0_at = obs.size();
        n_full0++;
      end
      if (buff1full) n_full1++;
      if (frame_done) n_done++;
      if (m_write && m_waitrequest) n_stall++;
      prev_stall = m_write && m_waitrequest && !reset;
      p_addr = m_address; p_data = m_writedata; p_be = m_byteenable;
    end
  end

  task automatic do_reset();
    reset = 1'b1; start_capture = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    pix_data = 8'd0; m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    obs.delete(); n_full0 = 0; n_full1 = 0; n_done = 0; full0_at = -1; n_stall = 0;
  endtask

  task automatic cfg(input logic [15:0] w, input logic [15:0] h);
    width = w; height = h; buff0 = 32'h1000; buff1 = 32'h2000; start_capture = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic sof);
    int n = 0;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      n++;
      if (n > 50) begin
        check("pix_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1 pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send_pix(first + 8'(i), i == 0);
  endtask

  task automatic stall_word(input int nth);
    int seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (m_write) begin
        seen++;
        if (seen == nth) begin
          m_waitrequest = 1'b1;
          repeat (3) @(posedge clk);
          #1 m_waitrequest = 1'b0;
          return;
        end
      end
    end
    check("stall_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input int t);
    int k = 0;
    check($sformatf("t%0d_nwr", t), obs.size(), sum_tbl[t].n_wr);
    for (int i = 0; i < wr_tbl.size(); i++) begin
      if (wr_tbl[i].test == t) begin
        if (k < obs.size()) begin
          check($sformatf("t%0d_addr%0d", t, k), obs[k].addr, wr_tbl[i].addr);
          check($sformatf("t%0d_data%0d", t, k), obs[k].data, wr_tbl[i].data);
          check($sformatf("t%0d_be%0d", t, k), {28'd0, obs[k].be}, {28'd0, wr_tbl[i].be});
        end
        k++;
      end
    end
    check($sformatf("t%0d_full0", t), n_full0, sum_tbl[t].full0);
    check($sformatf("t%0d_full1", t), n_full1, sum_tbl[t].full1);
    check($sformatf("t%0d_done", t), n_done, sum_tbl[t].done);
    check($sformatf("t%0d_full0_at", t), full0_at, sum_tbl[t].full0_at);
  endtask

  initial begin
    // Expected writes per scenario (hand-computed).
    add_wr(1, 32'h1000, 32'h03020100, 4'hF); add_wr(1, 32'h1004, 32'h07060504, 4'hF);
    add_wr(1, 32'h2000, 32'h0B0A0908, 4'hF); add_wr(1, 32'h2004, 32'h0F0E0D0C, 4'hF);
    add_wr(2, 32'h1000, 32'h03020100, 4'hF); add_wr(2, 32'h1004, 32'h00000004, 4'h1);
    add_wr(3, 32'h1000, 32'h23222120, 4'hF); add_wr(3, 32'h1004, 32'h27262524, 4'hF);
    add_wr(3, 32'h2000, 32'h2B2A2928, 4'hF); add_wr(3, 32'h2004, 32'h2F2E2D2C, 4'hF);
    add_wr(4, 32'h1000, 32'h43424140, 4'hF); add_wr(4, 32'h1004, 32'h47464544, 4'hF);
    add_wr(4, 32'h1000, 32'h4E4D4C4B, 4'hF); add_wr(4, 32'h1004, 32'h5251504F, 4'hF);
    add_wr(4, 32'h2000, 32'h56555453, 4'hF); add_wr(4, 32'h2004, 32'h5A595857, 4'hF);
    add_wr(5, 32'h1000, 32'h63626160, 4'hF); add_wr(5, 32'h2000, 32'h67666564, 4'hF);
    //            n_wr full0 full1 done full0_at
    sum_tbl[1] = '{4, 1, 1, 1, 2};
    sum_tbl[2] = '{2, 1, 0, 1, 2};
    sum_tbl[3] = '{4, 1, 1, 1, 2};
    sum_tbl[4] = '{6, 2, 1, 1, 2};
    sum_tbl[5] = '{2, 1, 1, 1, 1};
    sum_tbl[6] = '{0, 0, 0, 0, -1};
    width = 16'd0; height = 16'd0; buff0 = 32'd0; buff1 = 32'd0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_m_write", {31'd0, m_write}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
    check("rst_m_address", m_address, 32'd0);
    check("rst_pulses", {29'd0, buff0full, buff1full, frame_done}, 32'd0);

    // 1: 8x2 frame; mid-frame config changes must be ignored
    do_reset(); cfg(16'd8, 16'd2);
    send_pix(8'h00, 1'b1);
    width = 16'd3; height = 16'd5; buff0 = 32'hDEAD0000;
    for (int i = 1; i < 16; i++) send_pix(8'(i), 1'b0);
    repeat (12) @(negedge clk);
    verify(1);
    check("t1_busy_wait_sof", {31'd0, busy}, 32'd1);

    // 2: partial last word
    do_reset(); cfg(16'd5, 16'd1);
    send_run(8'h00, 5);
    repeat (12) @(negedge clk);
    verify(2);

    // 3: 3-cycle stall on the second word
    do_reset(); cfg(16'd8, 16'd2);
    fork
      send_run(8'h20, 16);
      stall_word(2);
    join
    repeat (12) @(negedge clk);
    verify(3);
    check("t3_stall_cycles", n_stall, 32'd3);

    // 4: sof on pixel 3 of line 1 aborts and restarts
    do_reset(); cfg(16'd8, 16'd2);
    send_run(8'h40, 11);
    send_run(8'h4B, 16);
    repeat (12) @(negedge clk);
    verify(4);

    // 5: start_capture dropped in line 0; later sof ignored
    do_reset(); cfg(16'd4, 16'd2);
    send_pix(8'h60, 1'b1); send_pix(8'h61, 1'b0);
    start_capture = 1'b0;
    for (int i = 2; i < 8; i++) send_pix(8'h60 + 8'(i), 1'b0);
    repeat (12) @(negedge clk);
    verify(5);
    check("t5_busy_idle", {31'd0, busy}, 32'd0);
    send_run(8'h70, 4);
    repeat (12) @(negedge clk);
    check("t5_sof_ignored_nwr", obs.size(), 32'd2);
    check("t5_sof_ignored_busy", {31'd0, busy}, 32'd0);

    // 6: reset while a write is stalled mid-line
    do_reset(); cfg(16'd8, 16'd2);
    send_run(8'h80, 4);
    m_waitrequest = 1'b1; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_m_write", {31'd0, m_write}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; m_waitrequest = 1'b0;
    repeat (12) @(negedge clk);
    verify(6);

`ifdef FRAME_CNT_EN
    do_reset(); cfg(16'd4, 16'd1);
    for (int f = 0; f < 3; f++) send_run(8'h90, 4);
    send_pix(8'hA0, 1'b1); send_pix(8'hA1, 1'b0); send_pix(8'hA2, 1'b1);
    repeat (12) @(negedge clk);
    check("frame_count", {16'd0, frame_count}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
